baud_sched: RTL and testbench
=============================

# baud_sched

Programmable baud-tick scheduler for the UART. It owns the shared bit-timing resource, a clock divider running from `in_clk`, and exposes two strobes to the datapath. `rx_tick` is an oversampling strobe for the receiver; `tx_tick` is the bit strobe for the transmitter. Divisor reconfiguration uses a valid/ready handshake and takes effect only on a TX bit boundary, so a frame in flight is never distorted.

## Interface
- `F_IN`, 50_000_000, input clock frequency in Hz.
- `DEFAULT_BAUD`, 9600, baud rate loaded at reset.
- `OVS`, 16, oversampling factor (`rx_tick` events per `tx_tick`); must be ≥2.
- `DIV_W`, 16, width of the divisor register.
- `in_clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; 0 holds the scheduler idle.
- `cfg_div`  in  DIV_W  requested divisor, in `in_clk` cycles per `rx_tick`.
- `cfg_valid`  in  1  a `cfg_div` value is offered.
- `cfg_ready`  out  1  the scheduler can accept a divisor.
- `rx_tick`  out  1  one-cycle oversample strobe.
- `tx_tick`  out  1  one-cycle bit strobe.
- `div_cur`  out  DIV_W  divisor currently in effect.
- `sync_req`  in  1  receiver phase-realign request. Present only with `BAUD_SCHED_SYNC_EN`.

## Operation
- Reset divisor `DIV0` = round-to-nearest of F_IN/(DEFAULT_BAUD·OVS), computed as (F_IN + DEFAULT_BAUD·OVS/2)/(DEFAULT_BAUD·OVS). With the default parameters this gives 326.
- Registers:
  - `div_reg`, the active divisor.
  - `shadow`, the pending divisor.
  - `div_cnt`, DIV_W bits, counts 0..div_reg−1.
  - `ovs_cnt`, clog2(OVS) bits, counts 0..OVS−1.
- States:
  - IDLE: counters held at 0. No ticks. `cfg_ready`=1.
  - RUN: counters advance. `cfg_ready`=1.
  - PEND: counters advance. `cfg_ready`=0. `shadow` is waiting to be applied.
- Transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE or PEND→IDLE when `en`=0.
  - RUN→PEND on a handshake (`cfg_valid`&`cfg_ready`).
  - PEND→RUN on the cycle `tx_tick` is high.
- Handshake in IDLE: `div_reg` ← `cfg_div` at the next edge.
- Handshake in RUN: `shadow` ← `cfg_div`, then enter PEND.
- Apply in PEND: on the `tx_tick` cycle, `div_reg` ← `shadow` and both counters restart at 0.
- Accepted `cfg_div` values <2 are clamped to 2.
- Counting:
  - `div_cnt` increments every cycle in RUN/PEND and wraps to 0 at div_reg−1.
  - `rx_tick` = (RUN|PEND) & (div_cnt == div_reg−1).
  - `ovs_cnt` increments on each `rx_tick` and wraps at OVS−1.
  - `tx_tick` = rx_tick & (ovs_cnt == OVS−1).
- Simultaneous events:
  - `en` falls while in PEND: `shadow` is applied on the IDLE entry edge and no tick is issued.
  - `en`=0 and a handshake in the same cycle: the handshake is accepted and applied as in IDLE.
- Ticks are decoded from registers only. There is no combinational path from an input to any output.

## Timing
- Reset values:
  - state IDLE; `div_reg` = DIV0; `shadow` = DIV0.
  - counters 0.
  - `rx_tick` 0; `tx_tick` 0; `cfg_ready` 1; `div_cur` DIV0.
- Reset asserted mid-operation aborts immediately, including any pending divisor. Outputs take their reset values asynchronously.
- Tick latency:
  - `en` sampled high at edge k gives RUN from edge k.
  - First `rx_tick` is in cycle k+div_reg−1.
  - First `tx_tick` follows div_reg·OVS cycles after entering RUN.
- Steady state: `rx_tick` period = div_reg cycles; `tx_tick` period = div_reg·OVS cycles. `tx_tick` always coincides with an `rx_tick`.
- Reconfiguration:
  - `cfg_ready` falls the cycle after acceptance in RUN.
  - It rises the cycle after the applying `tx_tick`.
  - The first new-rate `rx_tick` arrives new_div cycles after that edge.
- `div_cur` updates on the same edge as `div_reg`.

## Configuration
- `BAUD_SCHED_SYNC_EN` defined:
  - Adds the `sync_req` input.
  - `sync_req`=1 in RUN/PEND clears `div_cnt` and `ovs_cnt` at the next edge.
  - No tick is issued in that cycle.
  - PEND is kept, and the pending divisor waits for the next `tx_tick`.
  - `sync_req` is ignored in IDLE.
  - Used by the receiver to align sampling to a start-bit edge.
- Not defined: the port is absent and counters run free.

## Test plan
- Reset/idle: `nrst`=0 for 100 ns, then `en`=0 for 2000 cycles → no ticks, `div_cur`=326, `cfg_ready`=1.
- Default rate: `en`=1 → `rx_tick` every 326 cycles and `tx_tick` every 5216 cycles, with every `tx_tick` on an `rx_tick`.
- Live reconfig: in RUN, offer `cfg_div`=27 mid-bit.
  - `cfg_ready` drops.
  - The old 326 period is kept until the next `tx_tick`.
  - Thereafter `rx_tick` comes every 27 cycles and `tx_tick` every 432 cycles.
- Clamp and idle load: with `en`=0, offer `cfg_div`=0 → `div_cur`=2. Then `en`=1 → `rx_tick` every 2 cycles.
- Disable during PEND and reset mid-run:
  - `en`=0 while PEND → IDLE, `shadow` applied, no tick.
  - `nrst` pulsed low mid-count → immediate return to reset values and `div_cur`=326.
- With `BAUD_SCHED_SYNC_EN`: pulse `sync_req` at `div_cnt`=100 → that tick is dropped, and the next `rx_tick` follows 326 cycles after the sync edge.

Source files
------------

// File: rtl/baud_sched.sv
// Baud-tick scheduler: divides in_clk into an oversampling strobe (rx_tick) and a bit strobe (tx_tick).
// Optional BAUD_SCHED_SYNC_EN adds sync_req for receiver phase realignment.
module baud_sched #(
   parameter int F_IN         = 50_000_000,
   parameter int DEFAULT_BAUD = 9600,
   parameter int OVS          = 16,
   parameter int DIV_W        = 16
) (
   input  logic             in_clk,
   input  logic             nrst,
   input  logic             en,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_valid,
`ifdef BAUD_SCHED_SYNC_EN
   input  logic             sync_req,
`endif
   output logic             cfg_ready,
   output logic             rx_tick,
   output logic             tx_tick,
   output logic [DIV_W-1:0] div_cur
);

   localparam int               OVS_W    = $clog2(OVS);
   localparam int               BAUD_OVS = DEFAULT_BAUD * OVS;
   localparam int               DIV0_INT = (F_IN + BAUD_OVS / 2) / BAUD_OVS;
   localparam logic [DIV_W-1:0] DIV0     = DIV_W'(DIV0_INT);
   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] div_cnt;
   logic [OVS_W-1:0] ovs_cnt;

   logic             active;
   logic             handshake;
   logic             sync_hit;
   logic [DIV_W-1:0] div_last;
   logic [DIV_W-1:0] cfg_clamped;
   logic [DIV_W-1:0] div_cnt_adv;
   logic [OVS_W-1:0] ovs_cnt_adv;

   // All outputs are decoded from registered state only.
   assign active      = (state == RUN) || (state == PEND);
   assign div_last    = div_reg - DIV_W'(1);
   assign rx_tick     = active && (div_cnt == div_last);
   assign tx_tick     = rx_tick && (ovs_cnt == OVS_LAST);
   assign cfg_ready   = (state != PEND);
   assign div_cur     = div_reg;
   assign handshake   = cfg_valid && cfg_ready;
   assign cfg_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

`ifdef BAUD_SCHED_SYNC_EN
   assign sync_hit = sync_req && active;
`else
   assign sync_hit = 1'b0;
`endif

   always_comb begin
      div_cnt_adv = div_cnt + DIV_W'(1);
      ovs_cnt_adv = ovs_cnt;
      if (rx_tick) begin
         div_cnt_adv = '0;
         ovs_cnt_adv = (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
      end
   end

   // A dropped enable always wins: a pending shadow is applied on the way to IDLE.
   always_ff @(posedge in_clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         div_reg <= DIV0;
         shadow  <= DIV0;
         div_cnt <= '0;
         ovs_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= '0;
               ovs_cnt <= '0;
               if (handshake) div_reg <= cfg_clamped;
               if (en) state <= RUN;
            end
            RUN: begin
               if (!en) begin
                  state   <= IDLE;
                  div_cnt <= '0;
                  ovs_cnt <= '0;
                  if (handshake) div_reg <= cfg_clamped;
               end else begin
                  if (handshake) begin
                     shadow <= cfg_clamped;
                     state  <= PEND;
                  end
                  if (sync_hit) begin
                     div_cnt <= '0;
                     ovs_cnt <= '0;
                  end else begin
                     div_cnt <= div_cnt_adv;
                     ovs_cnt <= ovs_cnt_adv;
                  end
               end
            end
            PEND: begin
               if (!en) begin
                  state   <= IDLE;
                  div_reg <= shadow;
                  div_cnt <= '0;
                  ovs_cnt <= '0;
               end else if (sync_hit) begin
                  div_cnt <= '0;
                  ovs_cnt <= '0;
               end else if (tx_tick) begin
                  state   <= RUN;
                  div_reg <= shadow;
                  div_cnt <= '0;
                  ovs_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt_adv;
                  ovs_cnt <= ovs_cnt_adv;
               end
            end
            default: begin
               state   <= IDLE;
               div_cnt <= '0;
               ovs_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_baud_sched.sv
// Self-checking bench for baud_sched: tick-time scoreboard plus a table of idle-mode config vectors.
module tb_baud_sched;

   localparam int OVS  = 16;
   localparam int DIV0 = 326;

   logic        in_clk = 1'b0;
   logic        nrst = 1'b0;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div = 16'd0;
`ifdef BAUD_SCHED_SYNC_EN
   logic        sync_req = 1'b0;
`endif
   logic        cfg_ready;
   logic        rx_tick;
   logic        tx_tick;
   logic [15:0] div_cur;

   int cyc = 0;
   int tests_run = 0;
   int tests_failed = 0;
   int exp_rx[$];
   int exp_tx[$];

   typedef struct {
      logic        en;
      logic        valid;
      logic [15:0] div;
      logic        exp_ready;
      logic [15:0] exp_div;
   } vec_t;

   vec_t vecs[6];

   baud_sched dut (
      .in_clk   (in_clk),
      .nrst     (nrst),
      .en       (en),
      .cfg_div  (cfg_div),
      .cfg_valid(cfg_valid),
`ifdef BAUD_SCHED_SYNC_EN
      .sync_req (sync_req),
`endif
      .cfg_ready(cfg_ready),
      .rx_tick  (rx_tick),
      .tx_tick  (tx_tick),
      .div_cur  (div_cur)
   );

   always #5 in_clk = ~in_clk;

   always @(posedge in_clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic record_fail(input string name, input int actual);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected none (cycle %0d)", name, actual, cyc);
   endtask

   // Every tick the DUT emits must match the next expected tick time.
   always @(negedge in_clk) begin
      if (tx_tick) check_output("tx_on_rx", int'(rx_tick), 1);
      if (rx_tick) begin
         if (exp_rx.size() == 0) record_fail("rx_unexpected", cyc);
         else check_output("rx_cycle", cyc, exp_rx.pop_front());
      end
      if (tx_tick) begin
         if (exp_tx.size() == 0) record_fail("tx_unexpected", cyc);
         else check_output("tx_cycle", cyc, exp_tx.pop_front());
      end
   end

   task automatic step();
      @(negedge in_clk);
      #1;
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) step();
   endtask

   task automatic start_run(output int k);
      en = 1'b1;
      k = cyc + 1;
   endtask

   task automatic push_ticks(input int k, input int div, input int n);
      for (int i = 0; i < n; i++) begin
         exp_rx.push_back(k + div - 1 + i * div);
         if (((i + 1) % OVS) == 0) exp_tx.push_back(k + div - 1 + i * div);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_rx.size() != 0 || exp_tx.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check_output(name, exp_rx.size() + exp_tx.size(), 0);
      exp_rx.delete();
      exp_tx.delete();
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      en        = v.en;
      cfg_valid = v.valid;
      cfg_div   = v.div;
      step();
      check_output($sformatf("vec%0d_ready", idx), int'(cfg_ready), int'(v.exp_ready));
      check_output($sformatf("vec%0d_div", idx), int'(div_cur), int'(v.exp_div));
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_div"}, int'(div_cur), DIV0);
      check_output({tag, "_ready"}, int'(cfg_ready), 1);
      check_output({tag, "_rx"}, int'(rx_tick), 0);
      check_output({tag, "_tx"}, int'(tx_tick), 0);
   endtask

   initial begin
      int k;
      int k3;
      int t;

      vecs[0] = '{en: 1'b0, valid: 1'b1, div: 16'd27,  exp_ready: 1'b1, exp_div: 16'd27};
      vecs[1] = '{en: 1'b0, valid: 1'b1, div: 16'd0,   exp_ready: 1'b1, exp_div: 16'd2};
      vecs[2] = '{en: 1'b0, valid: 1'b1, div: 16'd1,   exp_ready: 1'b1, exp_div: 16'd2};
      vecs[3] = '{en: 1'b0, valid: 1'b0, div: 16'd500, exp_ready: 1'b1, exp_div: 16'd2};
      vecs[4] = '{en: 1'b0, valid: 1'b1, div: 16'd326, exp_ready: 1'b1, exp_div: 16'd326};
      vecs[5] = '{en: 1'b0, valid: 1'b1, div: 16'd0,   exp_ready: 1'b1, exp_div: 16'd2};

      // Reset and a long idle stretch with no ticks.
      #50;
      check_reset_values("in_reset");
      #51;
      nrst = 1'b1;
      at_cycle(cyc + 2000);
      check_output("idle_div", int'(div_cur), DIV0);
      check_output("idle_ready", int'(cfg_ready), 1);

      // Default rate over two full bits.
      start_run(k);
      push_ticks(k, DIV0, 2 * OVS);
      wait_drain("default_drain", DIV0 * (2 * OVS + 2));
      en = 1'b0;
      step();

      // Live reconfiguration mid-bit: old rate held until the next tx_tick.
      start_run(k);
      push_ticks(k, DIV0, OVS);
      t = k + DIV0 * OVS - 1;
      push_ticks(t + 1, 27, 2 * OVS);
      at_cycle(k + 1000);
      cfg_div   = 16'd27;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      check_output("reconf_ready_drop", int'(cfg_ready), 0);
      at_cycle(t);
      check_output("reconf_ready_hold", int'(cfg_ready), 0);
      check_output("reconf_div_hold", int'(div_cur), DIV0);
      at_cycle(t + 1);
      check_output("reconf_ready_rise", int'(cfg_ready), 1);
      check_output("reconf_div_new", int'(div_cur), 27);
      wait_drain("reconf_drain", 27 * (2 * OVS + 2));
      en = 1'b0;
      step();

      // Idle loads and clamping, then run at the minimum divisor.
      for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);
      cfg_valid = 1'b0;
      start_run(k);
      push_ticks(k, 2, 2 * OVS);
      wait_drain("clamp_drain", 2 * (2 * OVS + 4));
      en = 1'b0;
      step();

      // Disable while PEND: shadow applied on IDLE entry, no tick afterwards.
      cfg_div   = 16'd40;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      check_output("load40_div", int'(div_cur), 40);
      start_run(k);
      push_ticks(k, 40, 4);
      at_cycle(k + 130);
      cfg_div   = 16'd100;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      check_output("pend_ready", int'(cfg_ready), 0);
      at_cycle(k + 165);
      en = 1'b0;
      step();
      check_output("pend_abort_div", int'(div_cur), 100);
      check_output("pend_abort_ready", int'(cfg_ready), 1);
      at_cycle(k + 300);
      wait_drain("pend_abort_drain", 1);
      start_run(k3);
      push_ticks(k3, 100, 2);
      wait_drain("after_abort_drain", 250);

      // Handshake in the same cycle enable drops: applied as in IDLE.
      at_cycle(cyc + 5);
      en        = 1'b0;
      cfg_div   = 16'd55;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      check_output("en_drop_hs_div", int'(div_cur), 55);
      check_output("en_drop_hs_ready", int'(cfg_ready), 1);
      at_cycle(cyc + 150);

      // Reset pulse mid-run with a divisor pending.
      start_run(k);
      push_ticks(k, 55, 2);
      at_cycle(k + 130);
      cfg_div   = 16'd77;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      check_output("pre_reset_ready", int'(cfg_ready), 0);
      at_cycle(k + 140);
      nrst = 1'b0;
      #1;
      check_reset_values("mid_reset");
      en = 1'b0;
      step();
      step();
      nrst = 1'b1;
      at_cycle(cyc + 400);
      check_output("post_reset_div", int'(div_cur), DIV0);
      wait_drain("reset_drain", 1);

`ifdef BAUD_SCHED_SYNC_EN
      // Sync at div_cnt=100 drops the pending tick and restarts the phase.
      start_run(k);
      at_cycle(k + 100);
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
      push_ticks(k + 101, DIV0, 2);
      wait_drain("sync_drain", 3 * DIV0);
      en = 1'b0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
